// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and constants for the clock divider controller
package clk_div_pkg;

    localparam int DEF_W   = 8;
    localparam int MIN_DIV = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_cnt.sv
// rtl/clk_div_cnt.sv - mod-N period counter with load, enable and terminal flag
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] mod,
    output logic [W-1:0] cnt,
    output logic         term
);

    assign term = (cnt == (mod - W'(1)));

    // Count 0..mod-1 and wrap; load takes priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= term ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock-enable divider with graceful stop and queued ratio change
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         div_out,
    output logic         tick,
    output logic [W-1:0] cur_div,
    output logic         busy
);

    state_e       state;
    logic [W-1:0] cnt;
    logic [W-1:0] pend_div;
    logic         pend;
    logic         term;
    logic         boundary;
    logic         accept;
    logic         legal;
    logic [W:0]   half;

    assign busy      = (state != ST_IDLE);
    assign boundary  = busy && term;
    assign cfg_ready = !pend;
    assign accept    = cfg_valid && cfg_ready;
    assign legal     = (cfg_div >= W'(MIN_DIV));

    // High phase is ceil(cur_div/2); one extra bit keeps the maximum ratio from overflowing.
    assign half    = ({1'b0, cur_div} + (W+1)'(1)) >> 1;
    assign div_out = busy && ({1'b0, cnt} < half);
    assign tick    = busy && (cnt == '0);

    // Counter runs only while busy and is held at zero in IDLE.
    clk_div_cnt #(.W(W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (busy),
        .load     (!busy),
        .load_val ('0),
        .mod      (cur_div),
        .cnt      (cnt),
        .term     (term)
    );

    // Run/stop state machine; stopping always waits for the end of the current period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_RUN;
                end
                ST_RUN: begin
                    // en dropping on the last cycle of a period stops right there.
                    if (!en && boundary) state <= ST_IDLE;
                    else if (!en)        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (en)            state <= ST_RUN;
                    else if (boundary) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ratio handshake: immediate update when idle, otherwise queued until a period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_div  <= W'(DEFAULT_DIV);
            pend_div <= W'(DEFAULT_DIV);
            pend     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= accept && !legal;
            if (pend && (boundary || !busy)) begin
                cur_div <= pend_div;
                pend    <= 1'b0;
            end
            // accept implies pend is clear, so this never collides with the apply above.
            if (accept && legal) begin
                if (busy) begin
                    pend_div <= cfg_div;
                    pend     <= 1'b1;
                end else begin
                    cur_div <= cfg_div;
                end
            end
        end
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter W, default 8: width of divide ratio and counter.
REQ-002 Parameter DEFAULT_DIV, default 4: ratio loaded at reset; SHALL be 2..2^W-1.
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 en  in  1  run request; 1 = run divider, 0 = graceful stop at period boundary.
REQ-006 cfg_valid  in  1  new ratio offered.
REQ-007 cfg_div  in  W  requested ratio D (output period in clk cycles).
REQ-008 cfg_ready  out  1  controller can accept a ratio.
REQ-009 cfg_err  out  1  one-cycle pulse: accepted ratio was illegal (<2), discarded.
REQ-010 div_out  out  1  divided clock-enable waveform.
REQ-011 tick  out  1  one-cycle pulse at start of each output period.
REQ-012 cur_div  out  W  ratio currently in effect.
REQ-013 busy  out  1  state is RUN or DRAIN.

Function
REQ-014 States SHALL be IDLE, RUN and DRAIN; a separate pend flag SHALL hold one queued ratio.
REQ-015 Counter cnt SHALL count 0..cur_div-1, wrapping to 0, advancing only in RUN or DRAIN.
REQ-016 div_out SHALL equal busy AND (cnt < ceil(cur_div/2)); decode of registered state, no extra latency.
REQ-017 tick SHALL equal busy AND cnt==0.
REQ-018 Boundary SHALL mean busy AND cnt==cur_div-1.
REQ-019 IDLE->RUN when en=1; cnt=0 next cycle, so tick and div_out rise one cycle after en is sampled high.
REQ-020 RUN->DRAIN when en=0; cnt keeps counting, so the current period completes without truncation.
REQ-021 DRAIN->RUN when en=1 before boundary; no period restart, counting continues.
REQ-022 DRAIN->IDLE at boundary; cnt=0, div_out=0, tick=0 while IDLE.
REQ-023 cfg_ready SHALL equal NOT pend; handshake completes on cfg_valid AND cfg_ready.
REQ-024 Accepted cfg_div<2: cfg_err=1 next cycle, no state or ratio change, pend unchanged.
REQ-025 Accepted legal ratio in IDLE: cur_div updates next cycle, pend stays 0.
REQ-026 Accepted legal ratio in IDLE with en=1 the same cycle: RUN starts with the new ratio.
REQ-027 Accepted legal ratio in RUN or DRAIN: stored, pend=1, applied at the next boundary after acceptance (cur_div updated, cnt=0, pend=0).
REQ-028 Acceptance on a boundary cycle SHALL NOT apply at that boundary; it applies at the following one.
REQ-029 DRAIN->IDLE with pend=1: pending ratio SHALL load into cur_div on entering IDLE.
REQ-030 cur_div SHALL never change mid-period; div_out SHALL have no pulse shorter than floor(cur_div/2) cycles.

Reset
REQ-031 On rst: state=IDLE, cnt=0, pend=0, cur_div=DEFAULT_DIV, div_out=0, tick=0, cfg_err=0, busy=0, cfg_ready=1.
REQ-032 rst asserted mid-period SHALL drop the queued ratio and force outputs low immediately; no period completion.

Structure
REQ-033 Shared package clk_div_pkg SHALL hold the state enum, MIN_DIV=2 and the default W.
REQ-034 Single sub-module clk_div_cnt (mod-N counter with load, enable and terminal flag) SHALL be instantiated; FSM and handshake stay in the top.

Verification
REQ-035 Reset, en=1, DEFAULT_DIV=4 -> tick every 4 cycles, div_out 2 high/2 low, busy=1.
REQ-036 Running D=4, offer D=5 at cnt=1 -> cfg_ready low until boundary; next period 5 cycles, div_out 3 high/2 low.
REQ-037 Running D=6, drop en at cnt=2 -> 3 more cycles counted, then IDLE with div_out=0 and no tick.
REQ-038 Offer cfg_div=1 -> cfg_err pulse one cycle, cur_div unchanged, waveform unaffected.
REQ-039 Offer D=7 on boundary cycle of D=4 -> one more D=4 period, then D=7.
REQ-040 rst pulse at cnt=2 with pend=1 -> outputs 0 immediately, cur_div=4, pend=0, cfg_ready=1.
